// File: rtl/idma_byte_lane_buffer_if.sv
// Handshake bundle for the per-byte-lane buffer.
// Slave is the buffer side; master is the producer/consumer side.
interface idma_byte_lane_buffer_if #(
  parameter int unsigned StrbWidth = 16
);
  logic [StrbWidth*8-1:0] in_data_i;
  logic [StrbWidth-1:0]   in_valid_i;
  logic [StrbWidth-1:0]   in_ready_o;
  logic [StrbWidth*8-1:0] out_data_o;
  logic [StrbWidth-1:0]   out_valid_o;
  logic [StrbWidth-1:0]   out_ready_i;

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o
  );

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o
  );
endinterface

// File: rtl/idma_byte_lane_buffer.sv
// Per-byte-lane FIFO buffer: StrbWidth independent byte FIFOs, each pushed and
// popped on its own strobe. No fall-through and no ready-to-ready path.

// One byte lane: depth need not be a power of two, pointers wrap explicitly.
module idma_byte_lane_fifo #(
  parameter int unsigned Depth = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       full_o
);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(Depth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      mem_q [Depth];
  logic [7:0]      mem_d [Depth];
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Ready ignores out_ready_i on purpose: a full lane stays closed even while popping.
  assign full_o      = (cnt_q == CntMax);
  assign in_ready_o  = ~full_o & ~clear_i & ~rst_i;
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rptr_q] : 8'h00;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Next pointer/count; reset and clear both flush, reset taking priority.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (rst_i || clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Next storage contents: only the slot under the write pointer changes.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = in_data_i;
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; count gates visibility.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> in_ready_o);
  a_cnt_bound : assert property (@(posedge clk_i) cnt_q <= CntMax);
  a_in_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i & ~in_ready_o & ~clear_i) |=> (in_data_i == $past(in_data_i)));
endmodule

// Top: array of independent lanes plus the aggregate flags.
module idma_byte_lane_buffer #(
  parameter int unsigned StrbWidth   = 16,
  parameter int unsigned BufferDepth = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  idma_byte_lane_buffer_if.slave bus,
  output logic empty_o,
  output logic full_o
);
  logic [StrbWidth-1:0] lane_full;

  for (genvar g = 0; g < StrbWidth; g++) begin : g_lane
    idma_byte_lane_fifo #(.Depth(BufferDepth)) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .in_data_i   (bus.in_data_i[g*8 +: 8]),
      .in_valid_i  (bus.in_valid_i[g]),
      .in_ready_o  (bus.in_ready_o[g]),
      .out_data_o  (bus.out_data_o[g*8 +: 8]),
      .out_valid_o (bus.out_valid_o[g]),
      .out_ready_i (bus.out_ready_i[g]),
      .full_o      (lane_full[g])
    );
  end

  // full_o reflects occupancy only, not the clear/reset gating of in_ready_o.
  assign empty_o = ~|bus.out_valid_o;
  assign full_o  = |lane_full;
endmodule

// File: tb/tb_idma_byte_lane_buffer.sv
// Scoreboard bench: one reference queue per lane, compared every cycle.
module tb_idma_byte_lane_buffer;
  localparam int N = 16;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst, clr;
  logic empty, full;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [7:0]   q [N][$];
  logic [N-1:0] last_rdy;

  idma_byte_lane_buffer_if #(.StrbWidth(N)) bus ();

  idma_byte_lane_buffer #(.StrbWidth(N), .BufferDepth(D)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clr),
    .bus     (bus),
    .empty_o (empty),
    .full_o  (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive one cycle, check all outputs against the model, then advance it.
  task automatic step(input logic [N-1:0] v, input logic [N*8-1:0] d,
                      input logic [N-1:0] r, input logic c, input logic rs);
    logic [N-1:0]   e_rdy, e_vld;
    logic [N*8-1:0] e_dat;
    logic           e_full;
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = r;
    clr = c;
    rst = rs;
    #1;
    e_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      e_rdy[i] = (q[i].size() != D) && !c && !rs;
      e_vld[i] = (q[i].size() != 0);
      e_dat[i*8 +: 8] = e_vld[i] ? q[i][0] : 8'h00;
      if (q[i].size() == D) e_full = 1'b1;
    end
    chk("in_ready", bus.in_ready_o, e_rdy);
    chk("out_valid", bus.out_valid_o, e_vld);
    chk("out_data", bus.out_data_o, e_dat);
    chk("empty", empty, ~|e_vld);
    chk("full", full, e_full);
    last_rdy = e_rdy;
    for (int i = 0; i < N; i++) begin
      if (rs || c) q[i].delete();
      else begin
        if (r[i] && q[i].size() != 0) void'(q[i].pop_front());
        if (v[i] && e_rdy[i]) q[i].push_back(d[i*8 +: 8]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*8-1:0] dv;
    logic [N-1:0]   hv, rv, hold;
    logic           rc;
    bus.in_valid_i  = '0;
    bus.in_data_i   = '0;
    bus.out_ready_i = '0;
    clr = 1'b0;
    rst = 1'b1;
    #1;

    // Reset for two cycles, then ready opens on every lane.
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    chk("rst_data", bus.out_data_o, '0);
    step('0, '0, '0, 1'b0, 1'b0);

    // Fill/drain lane 0.
    step(16'h0001, 128'hA1, '0, 1'b0, 1'b0);
    step(16'h0001, 128'hA2, '0, 1'b0, 1'b0);
    step(16'h0001, 128'hA3, '0, 1'b0, 1'b0);
    chk("t2_full", full, 1'b1);
    chk("t2_rdy0", bus.in_ready_o[0], 1'b0);
    chk("t2_head", bus.out_data_o[7:0], 8'hA1);
    for (int k = 0; k < 3; k++) step('0, '0, 16'h0001, 1'b0, 1'b0);
    chk("t2_empty", empty, 1'b1);

    // Partial pop of lanes 4..7.
    for (int i = 0; i < N; i++) dv[i*8 +: 8] = 8'(i);
    step('1, dv, '0, 1'b0, 1'b0);
    step('0, '0, 16'h00F0, 1'b0, 1'b0);
    chk("t3_valid", bus.out_valid_o, 16'hFF0F);
    step('0, '0, 16'hFF0F, 1'b0, 1'b0);

    // Lane 5 full, push+pop same cycle: push rejected.
    for (int k = 0; k < 3; k++) step(16'h0020, 128'(8'h50 + k) << 40, '0, 1'b0, 1'b0);
    step(16'h0020, 128'h55 << 40, 16'h0020, 1'b0, 1'b0);
    chk("t4_notfull", full, 1'b0);
    chk("t4_head", bus.out_data_o[47:40], 8'h51);
    for (int k = 0; k < 10; k++) step(16'h0020, 128'(8'h55 + k) << 40, 16'h0020, 1'b0, 1'b0);
    chk("t4_wrap_head", bus.out_data_o[47:40], 8'h5D);
    step('0, '0, 16'h0020, 1'b0, 1'b0);
    step('0, '0, 16'h0020, 1'b0, 1'b0);

    // Clear mid-stream with pushes in flight.
    for (int k = 0; k < 2; k++) step(16'h000F, {N{8'(8'hC0 + k)}}, '0, 1'b0, 1'b0);
    step(16'h000F, {N{8'hEE}}, '0, 1'b1, 1'b0);
    chk("t5_empty", empty, 1'b1);
    step(16'h0001, 128'h77, '0, 1'b0, 1'b0);
    chk("t5_vis", bus.out_valid_o, 16'h0001);
    chk("t5_data", bus.out_data_o[7:0], 8'h77);
    step('0, '0, 16'h0001, 1'b0, 1'b0);

    // Random traffic; a refused push holds its data until accepted.
    hold = '0;
    hv   = '0;
    dv   = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          hv[i] = ($urandom_range(0, 2) != 0);
          dv[i*8 +: 8] = 8'($urandom);
        end
        rv[i] = ($urandom_range(0, 1) == 1) && (q[i].size() != 0);
      end
      rc = ($urandom_range(0, 299) == 0);
      step(hv, dv, rv, rc, 1'b0);
      hold = rc ? '0 : (hv & ~last_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
